// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries for the issue stage, captures
// CDB results, serves operand reads by ROB tag and retires the head in order.
// Tag 0 is reserved ("value lives in the register file"); live tags are
// 1..ROB_ENTRIES and both pointers wrap from ROB_ENTRIES back to 1.
// Optional feature macro: ROB_CDB_BYPASS_EN -- when defined, read ports
// forward a same-cycle non-store CDB result instead of waiting a cycle.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 3
`endif

module reorder_buffer #(
    parameter int ROB_ENTRIES = (1 << `ROB_TAG_LEN) - 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    alloc_enable,
    input  logic                    alloc_wr_mem,
    input  logic [4:0]              alloc_dest_reg,
    input  logic [`XLEN-1:0]        alloc_value_in,
    input  logic                    alloc_value_in_valid,
    input  logic [`ROB_TAG_LEN-1:0] alloc_store_dep,
    input  logic [2:0]              alloc_mem_size,
    output logic                    rob_full,
    output logic [`ROB_TAG_LEN-1:0] rob_tail_tag,
    input  logic [`ROB_TAG_LEN-1:0] rs1_rob_tag,
    input  logic [`ROB_TAG_LEN-1:0] rs2_rob_tag,
    output logic [`XLEN-1:0]        rs1_read_rob_value,
    output logic [`XLEN-1:0]        rs2_read_rob_value,
    output logic                    rs1_read_rob_ready,
    output logic                    rs2_read_rob_ready,
    input  logic                    cdb_valid,
    input  logic [`ROB_TAG_LEN-1:0] cdb_tag,
    input  logic [`XLEN-1:0]        cdb_value,
    output logic                    commit,
    output logic [`ROB_TAG_LEN-1:0] rob_entry_commit,
    output logic [4:0]              rd_commit,
    output logic [`XLEN-1:0]        commit_value,
    output logic                    commit_wr_mem,
    output logic [`XLEN-1:0]        commit_mem_addr,
    output logic [2:0]              commit_mem_size
);

    localparam int TW = `ROB_TAG_LEN;
    localparam int XW = `XLEN;
    localparam int CW = $clog2(ROB_ENTRIES + 1);
    localparam logic [TW-1:0] LAST_TAG   = TW'(ROB_ENTRIES);
    localparam logic [CW-1:0] FULL_COUNT = CW'(ROB_ENTRIES);

    logic [TW-1:0] head_reg, head_next;
    logic [TW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;

    logic alloc_do;
    logic commit_do;
    logic cdb_live;

    // Flattened per-entry views; index 0 is a permanently empty slot so a
    // tag can index these arrays directly.
    logic          valid_arr  [0:ROB_ENTRIES];
    logic          ready_arr  [0:ROB_ENTRIES];
    logic          wr_mem_arr [0:ROB_ENTRIES];
    logic [4:0]    dest_arr   [0:ROB_ENTRIES];
    logic [XW-1:0] value_arr  [0:ROB_ENTRIES];
    logic [XW-1:0] addr_arr   [0:ROB_ENTRIES];
    logic [2:0]    size_arr   [0:ROB_ENTRIES];

    // Store data as resolved at allocation time (shared by whichever entry is the tail).
    logic [XW-1:0] st_data;
    logic          st_data_ready;
    logic [TW-1:0] st_dep;

    function automatic logic [TW-1:0] ptr_inc(input logic [TW-1:0] p);
        return (p == LAST_TAG) ? TW'(1) : p + TW'(1);
    endfunction

    assign valid_arr[0]  = 1'b0;
    assign ready_arr[0]  = 1'b0;
    assign wr_mem_arr[0] = 1'b0;
    assign dest_arr[0]   = '0;
    assign value_arr[0]  = '0;
    assign addr_arr[0]   = '0;
    assign size_arr[0]   = '0;

    // Full is judged on the pre-edge count, so a full buffer that retires this
    // cycle still refuses the allocation.
    assign rob_full     = (count_reg == FULL_COUNT);
    assign rob_tail_tag = tail_reg;
    assign alloc_do     = alloc_enable && !rob_full;
    assign commit_do    = valid_arr[head_reg] && ready_arr[head_reg];
    assign cdb_live     = cdb_valid && (cdb_tag != '0) && valid_arr[cdb_tag];

    // Pointer and occupancy next-state.
    always_comb begin
        head_next  = commit_do ? ptr_inc(head_reg) : head_reg;
        tail_next  = alloc_do  ? ptr_inc(tail_reg) : tail_reg;
        count_next = count_reg + CW'(alloc_do) - CW'(commit_do);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg  <= TW'(1);
            tail_reg  <= TW'(1);
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Resolve store data for a new store: explicit value, same-cycle CDB of the
    // producer, or an already-finished producer entry; otherwise remember the dep.
    // A dep tag of 0 means the data came from the register file with the alloc.
    always_comb begin
        st_data       = alloc_value_in;
        st_data_ready = 1'b0;
        st_dep        = '0;
        if (alloc_value_in_valid || (alloc_store_dep == '0)) begin
            st_data_ready = 1'b1;
        end else if (cdb_live && (cdb_tag == alloc_store_dep)) begin
            st_data       = cdb_value;
            st_data_ready = 1'b1;
        end else if (valid_arr[alloc_store_dep] && ready_arr[alloc_store_dep]) begin
            st_data       = value_arr[alloc_store_dep];
            st_data_ready = 1'b1;
        end else begin
            st_dep = alloc_store_dep;
        end
    end

    for (genvar gi = 1; gi <= ROB_ENTRIES; gi++) begin : g_entry
        localparam logic [TW-1:0] MY_TAG = TW'(gi);

        logic          valid_reg;
        logic          ready_reg;
        logic          wr_mem_reg;
        logic          addr_ready_reg;
        logic          data_ready_reg;
        logic [4:0]    dest_reg;
        logic [XW-1:0] value_reg;
        logic [XW-1:0] addr_reg;
        logic [TW-1:0] dep_reg;
        logic [2:0]    size_reg;
        logic          alloc_hit;
        logic          commit_hit;

        assign alloc_hit  = alloc_do  && (tail_reg == MY_TAG);
        assign commit_hit = commit_do && (head_reg == MY_TAG);

        // Entry state: clear on reset/retire, load on allocate, else absorb CDB traffic.
        always_ff @(posedge clock) begin
            if (reset || commit_hit) begin
                valid_reg      <= 1'b0;
                ready_reg      <= 1'b0;
                wr_mem_reg     <= 1'b0;
                addr_ready_reg <= 1'b0;
                data_ready_reg <= 1'b0;
                dest_reg       <= '0;
                value_reg      <= '0;
                addr_reg       <= '0;
                dep_reg        <= '0;
                size_reg       <= '0;
            end else if (alloc_hit) begin
                valid_reg      <= 1'b1;
                wr_mem_reg     <= alloc_wr_mem;
                dest_reg       <= alloc_dest_reg;
                size_reg       <= alloc_mem_size;
                addr_reg       <= '0;
                addr_ready_reg <= 1'b0;
                if (alloc_wr_mem) begin
                    ready_reg      <= 1'b0;
                    value_reg      <= st_data;
                    data_ready_reg <= st_data_ready;
                    dep_reg        <= st_dep;
                end else begin
                    ready_reg      <= alloc_value_in_valid;
                    value_reg      <= alloc_value_in;
                    data_ready_reg <= 1'b0;
                    dep_reg        <= '0;
                end
            end else if (valid_reg) begin
                // Own result: stores receive their effective address here.
                if (cdb_live && (cdb_tag == MY_TAG)) begin
                    if (wr_mem_reg) begin
                        addr_reg       <= cdb_value;
                        addr_ready_reg <= 1'b1;
                    end else begin
                        value_reg <= cdb_value;
                        ready_reg <= 1'b1;
                    end
                end
                // Pending store data snooped from its producer's broadcast.
                if (wr_mem_reg && !data_ready_reg && cdb_live && (cdb_tag == dep_reg)) begin
                    value_reg      <= cdb_value;
                    data_ready_reg <= 1'b1;
                end
            end
        end

        assign valid_arr[gi]  = valid_reg;
        assign ready_arr[gi]  = wr_mem_reg ? (data_ready_reg && addr_ready_reg) : ready_reg;
        assign wr_mem_arr[gi] = wr_mem_reg;
        assign dest_arr[gi]   = dest_reg;
        assign value_arr[gi]  = value_reg;
        assign addr_arr[gi]   = addr_reg;
        assign size_arr[gi]   = size_reg;
    end

    // Two identical operand read ports.
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
        logic [TW-1:0] tag;
        logic [XW-1:0] val;
        logic          rdy;

        assign tag = (gi == 0) ? rs1_rob_tag : rs2_rob_tag;

        // Tag 0 reads as not-ready zero; store entries never report ready.
        always_comb begin
            val = '0;
            rdy = 1'b0;
            if (tag != '0) begin
                val = value_arr[tag];
                rdy = valid_arr[tag] && !wr_mem_arr[tag] && ready_arr[tag];
`ifdef ROB_CDB_BYPASS_EN
                if (cdb_live && (cdb_tag == tag) && !wr_mem_arr[cdb_tag]) begin
                    val = cdb_value;
                    rdy = 1'b1;
                end
`endif
            end
        end
    end

    assign rs1_read_rob_value = g_read[0].val;
    assign rs1_read_rob_ready = g_read[0].rdy;
    assign rs2_read_rob_value = g_read[1].val;
    assign rs2_read_rob_ready = g_read[1].rdy;

    // Commit outputs straight from the head; all zero when nothing retires.
    always_comb begin
        commit           = 1'b0;
        rob_entry_commit = '0;
        rd_commit        = '0;
        commit_value     = '0;
        commit_wr_mem    = 1'b0;
        commit_mem_addr  = '0;
        commit_mem_size  = '0;
        if (commit_do) begin
            commit           = 1'b1;
            rob_entry_commit = head_reg;
            commit_value     = value_arr[head_reg];
            commit_wr_mem    = wr_mem_arr[head_reg];
            if (wr_mem_arr[head_reg]) begin
                commit_mem_addr = addr_arr[head_reg];
                commit_mem_size = size_arr[head_reg];
            end else begin
                rd_commit = dest_arr[head_reg];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a vector table of per-cycle inputs with
// hand-computed expected outputs, plus short sequences for fill/full,
// mid-operation reset and the optional same-cycle CDB read forwarding.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 3
`endif

module tb_reorder_buffer;

    localparam int TW = `ROB_TAG_LEN;
    localparam int XW = `XLEN;
`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          alloc_enable, alloc_wr_mem, alloc_value_in_valid;
    logic [4:0]    alloc_dest_reg;
    logic [XW-1:0] alloc_value_in;
    logic [TW-1:0] alloc_store_dep;
    logic [2:0]    alloc_mem_size;
    logic          rob_full;
    logic [TW-1:0] rob_tail_tag;
    logic [TW-1:0] rs1_rob_tag, rs2_rob_tag;
    logic [XW-1:0] rs1_read_rob_value, rs2_read_rob_value;
    logic          rs1_read_rob_ready, rs2_read_rob_ready;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [XW-1:0] cdb_value;
    logic          commit;
    logic [TW-1:0] rob_entry_commit;
    logic [4:0]    rd_commit;
    logic [XW-1:0] commit_value;
    logic          commit_wr_mem;
    logic [XW-1:0] commit_mem_addr;
    logic [2:0]    commit_mem_size;

    always #5 clock = ~clock;

    reorder_buffer dut (
        .clock(clock), .reset(reset),
        .alloc_enable(alloc_enable), .alloc_wr_mem(alloc_wr_mem),
        .alloc_dest_reg(alloc_dest_reg), .alloc_value_in(alloc_value_in),
        .alloc_value_in_valid(alloc_value_in_valid), .alloc_store_dep(alloc_store_dep),
        .alloc_mem_size(alloc_mem_size), .rob_full(rob_full), .rob_tail_tag(rob_tail_tag),
        .rs1_rob_tag(rs1_rob_tag), .rs2_rob_tag(rs2_rob_tag),
        .rs1_read_rob_value(rs1_read_rob_value), .rs2_read_rob_value(rs2_read_rob_value),
        .rs1_read_rob_ready(rs1_read_rob_ready), .rs2_read_rob_ready(rs2_read_rob_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .commit(commit), .rob_entry_commit(rob_entry_commit), .rd_commit(rd_commit),
        .commit_value(commit_value), .commit_wr_mem(commit_wr_mem),
        .commit_mem_addr(commit_mem_addr), .commit_mem_size(commit_mem_size)
    );

    typedef struct {
        logic          alloc_en;
        logic          wr_mem;
        logic [4:0]    dest;
        logic [XW-1:0] val;
        logic          vv;
        logic [TW-1:0] dep;
        logic [2:0]    size;
        logic [TW-1:0] rs1;
        logic [TW-1:0] rs2;
        logic          cdb_v;
        logic [TW-1:0] cdb_t;
        logic [XW-1:0] cdb_val;
        logic          e_full;
        logic [TW-1:0] e_tail;
        logic          e_commit;
        logic [TW-1:0] e_ctag;
        logic [4:0]    e_rd;
        logic [XW-1:0] e_cval;
        logic          e_cwr;
        logic [XW-1:0] e_caddr;
        logic [2:0]    e_csize;
        logic [XW-1:0] e_rs1_val;
        logic          e_rs1_rdy;
        logic [XW-1:0] e_rs2_val;
        logic          e_rs2_rdy;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    // Idle cycle expecting the given tail tag and nothing else.
    function automatic vec_t vi(input logic [TW-1:0] tail);
        vec_t v;
        v = '{default: '0};
        v.e_tail = tail;
        return v;
    endfunction

    function automatic vec_t va(input logic [TW-1:0] tail, input logic wr, input logic [4:0] dest,
                                input logic [XW-1:0] val, input logic vv,
                                input logic [TW-1:0] dep, input logic [2:0] size);
        vec_t v;
        v = vi(tail);
        v.alloc_en = 1'b1; v.wr_mem = wr; v.dest = dest; v.val = val;
        v.vv = vv; v.dep = dep; v.size = size;
        return v;
    endfunction

    function automatic vec_t wc(input vec_t vin, input logic [TW-1:0] tag, input logic [XW-1:0] val);
        vec_t v;
        v = vin;
        v.cdb_v = 1'b1; v.cdb_t = tag; v.cdb_val = val;
        return v;
    endfunction

    function automatic vec_t wm(input vec_t vin, input logic [TW-1:0] tag, input logic [4:0] rd,
                                input logic [XW-1:0] val, input logic wr,
                                input logic [XW-1:0] addr, input logic [2:0] size);
        vec_t v;
        v = vin;
        v.e_commit = 1'b1; v.e_ctag = tag; v.e_rd = rd; v.e_cval = val;
        v.e_cwr = wr; v.e_caddr = addr; v.e_csize = size;
        return v;
    endfunction

    function automatic vec_t r1(input vec_t vin, input logic [TW-1:0] tag,
                                input logic [XW-1:0] val, input logic rdy);
        vec_t v;
        v = vin;
        v.rs1 = tag; v.e_rs1_val = val; v.e_rs1_rdy = rdy;
        return v;
    endfunction

    function automatic vec_t r2(input vec_t vin, input logic [TW-1:0] tag,
                                input logic [XW-1:0] val, input logic rdy);
        vec_t v;
        v = vin;
        v.rs2 = tag; v.e_rs2_val = val; v.e_rs2_rdy = rdy;
        return v;
    endfunction

    function automatic vec_t wf(input vec_t vin);
        vec_t v;
        v = vin;
        v.e_full = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alloc_enable         = v.alloc_en;
        alloc_wr_mem         = v.wr_mem;
        alloc_dest_reg       = v.dest;
        alloc_value_in       = v.val;
        alloc_value_in_valid = v.vv;
        alloc_store_dep      = v.dep;
        alloc_mem_size       = v.size;
        rs1_rob_tag          = v.rs1;
        rs2_rob_tag          = v.rs2;
        cdb_valid            = v.cdb_v;
        cdb_tag              = v.cdb_t;
        cdb_value            = v.cdb_val;
    endtask

    // Apply one cycle of inputs (called just after a rising edge), check at the
    // falling edge, then let the rising edge take effect.
    task automatic run_vec(input string name, input vec_t v);
        drive(v);
        @(negedge clock);
        chk($sformatf("%s full", name), 128'(rob_full), 128'(v.e_full));
        chk($sformatf("%s tail", name), 128'(rob_tail_tag), 128'(v.e_tail));
        chk($sformatf("%s commit", name),
            128'({commit, rob_entry_commit, rd_commit, commit_value, commit_wr_mem,
                  commit_mem_addr, commit_mem_size}),
            128'({v.e_commit, v.e_ctag, v.e_rd, v.e_cval, v.e_cwr, v.e_caddr, v.e_csize}));
        chk($sformatf("%s rs1", name), 128'({rs1_read_rob_value, rs1_read_rob_ready}),
            128'({v.e_rs1_val, v.e_rs1_rdy}));
        chk($sformatf("%s rs2", name), 128'({rs2_read_rob_value, rs2_read_rob_ready}),
            128'({v.e_rs2_val, v.e_rs2_rdy}));
        $display("[TB] %s alloc=%0b cdb=%0b/%0d commit=%0b tag=%0d tail=%0d full=%0b",
                 name, v.alloc_en, v.cdb_v, v.cdb_t, commit, rob_entry_commit,
                 rob_tail_tag, rob_full);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(vi(1));
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Main table: dependency chain with a store, out-of-order writeback,
        // same-cycle store-dep capture, and dep-already-ready capture.
        tbl.push_back(vi(1));                                                       // 0 reset state
        tbl.push_back(r1(va(1, 0, 2, 0, 0, 0, 0), 1, 0, 0));                        // 1 lw x2 -> tag1
        tbl.push_back(r1(va(2, 0, 3, 0, 0, 0, 0), 1, 0, 0));                        // 2 mul x3 -> tag2
        tbl.push_back(r1(va(3, 1, 0, 0, 0, 2, 3'b010), 2, 0, 0));                   // 3 sw dep2 -> tag3
        tbl.push_back(r1(wc(vi(4), 2, 32'h2A), 1, 0, 0));                           // 4 CDB tag2
        tbl.push_back(r2(r1(wc(vi(4), 3, 32'h1000), 2, 32'h2A, 1), 3, 32'h2A, 0));  // 5 CDB tag3 addr
        tbl.push_back(r1(wc(vi(4), 1, 32'h77), 3, 32'h2A, 0));                      // 6 CDB tag1
        tbl.push_back(r1(wm(vi(4), 1, 2, 32'h77, 0, 0, 0), 1, 32'h77, 1));          // 7 commit tag1
        tbl.push_back(wm(vi(4), 2, 3, 32'h2A, 0, 0, 0));                            // 8 commit tag2
        tbl.push_back(wm(vi(4), 3, 0, 32'h2A, 1, 32'h1000, 3'b010));                // 9 commit store
        tbl.push_back(r1(vi(4), 3, 0, 0));                                          // 10 retired entry cleared
        tbl.push_back(va(4, 0, 5, 0, 0, 0, 0));                                     // 11 tag4
        tbl.push_back(va(5, 0, 6, 0, 0, 0, 0));                                     // 12 tag5
        tbl.push_back(wc(vi(6), 5, 32'h55));                                        // 13 CDB tag5 first
        tbl.push_back(r1(vi(6), 5, 32'h55, 1));                                     // 14 head not ready
        tbl.push_back(wc(vi(6), 4, 32'h44));                                        // 15 CDB tag4
        tbl.push_back(wm(vi(6), 4, 5, 32'h44, 0, 0, 0));                            // 16 commit tag4
        tbl.push_back(wm(vi(6), 5, 6, 32'h55, 0, 0, 0));                            // 17 commit tag5
        tbl.push_back(vi(6));                                                       // 18 empty
        tbl.push_back(va(6, 0, 7, 0, 0, 0, 0));                                     // 19 lw x7 -> tag6
        tbl.push_back(wc(va(7, 1, 0, 0, 0, 6, 3'b000), 6, 32'h99));                 // 20 sb dep6 + CDB tag6
        tbl.push_back(r1(wm(wc(vi(1), 7, 32'h2000), 6, 7, 32'h99, 0, 0, 0), 7, 32'h99, 0)); // 21
        tbl.push_back(wm(vi(1), 7, 0, 32'h99, 1, 32'h2000, 3'b000));                // 22 commit sb
        tbl.push_back(va(1, 0, 8, 32'h123, 1, 0, 0));                               // 23 known value tag1
        tbl.push_back(wm(va(2, 1, 0, 0, 0, 1, 3'b001), 1, 8, 32'h123, 0, 0, 0));    // 24 sh dep1 ready
        tbl.push_back(r1(wc(vi(3), 2, 32'h3000), 2, 32'h123, 0));                   // 25 store addr
        tbl.push_back(wm(vi(3), 2, 0, 32'h123, 1, 32'h3000, 3'b001));               // 26 commit sh
        tbl.push_back(vi(3));                                                       // 27 empty

        drive(vi(1));
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Fill to full, ignored alloc, full+commit still rejects alloc.
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            run_vec($sformatf("fill%0d", k), va(TW'(k), 0, 5'(k), 0, 0, 0, 0));
        end
        run_vec("full_ignore", wf(va(1, 0, 9, 32'hEE, 1, 0, 0)));
        run_vec("full_hold", r1(wf(vi(1)), 1, 0, 0));
        run_vec("full_cdb", wf(wc(vi(1), 1, 32'hAB)));
        run_vec("full_commit", wm(wf(va(1, 0, 9, 32'hEE, 1, 0, 0)), 1, 1, 32'hAB, 0, 0, 0));
        run_vec("after_commit", r1(vi(1), 1, 0, 0));
        run_vec("refill", va(1, 0, 10, 32'hCD, 1, 0, 0));
        run_vec("refull", r1(wf(vi(2)), 1, 32'hCD, 1));

        // Reset with a full buffer discards everything.
        do_reset();
        run_vec("mid_reset", r2(r1(vi(1), 1, 0, 0), 2, 0, 0));

        // Same-cycle CDB read forwarding (only when the bypass is built in).
        for (int k = 1; k <= 4; k++) begin
            run_vec($sformatf("byp_alloc%0d", k), va(TW'(k), 0, 5'(k), 0, 0, 0, 0));
        end
        run_vec("byp_cdb4", r1(wc(vi(5), 4, 32'h55), 4, BYP ? 32'h55 : 32'h0, BYP));
        run_vec("byp_next", r1(vi(5), 4, 32'h55, 1));
        run_vec("byp_head", r1(wc(vi(5), 1, 32'h11), 1, BYP ? 32'h11 : 32'h0, BYP));
        run_vec("byp_commit", wm(vi(5), 1, 1, 32'h11, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
